// File: rtl/flt_to_fix_conv.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module      : flt_to_fix_conv                                             |
// | Description : Sequential float16 -> signed fixed 8.8 converter. The       |
// |               operand is captured on a start/ack handshake, its mantissa  |
// |               is shifted one bit per clock, and the result is presented   |
// |               in a register together with a saturation flag.              |
// | Revision    : 1.0 - initial release                                       |
// +---------------------------------------------------------------------------+
module flt_to_fix_conv #(
   parameter int MAX_RSHIFT = 11
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [15:0] flt_in,
   output logic        ack,
   output logic [15:0] fix_out,
   output logic        ovf
);

   // Exponent at which the 11-bit significand {1,mant} already is 8.8 aligned.
   localparam logic [4:0] EXP_UNITY = 5'd17;
   localparam logic [4:0] EXP_SAT   = 5'd22;
   localparam logic [4:0] MAX_RSH   = 5'(MAX_RSHIFT);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DECODE = 3'd1,
      S_SHIFT  = 3'd2,
      S_PACK   = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic        sign_q, sign_d;
   logic [4:0]  exp_q, exp_d;
   logic [15:0] mag_q, mag_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        dir_left_q, dir_left_d;
   logic        sat_q, sat_d;
   logic [15:0] fix_q, fix_d;
   logic        ovf_q, ovf_d;
   logic        ack_q, ack_d;

   // Right-shift distance; only meaningful while exp < 17.
   logic [4:0]  rsh_w;
   logic        mant_zero_w;

   assign rsh_w       = EXP_UNITY - exp_q;
   assign mant_zero_w = (mag_q[9:0] == 10'd0);

   // State and datapath registers; reset aborts any conversion at once.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         sign_q     <= 1'b0;
         exp_q      <= 5'd0;
         mag_q      <= 16'd0;
         cnt_q      <= 5'd0;
         dir_left_q <= 1'b0;
         sat_q      <= 1'b0;
         fix_q      <= 16'd0;
         ovf_q      <= 1'b0;
         ack_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         sign_q     <= sign_d;
         exp_q      <= exp_d;
         mag_q      <= mag_d;
         cnt_q      <= cnt_d;
         dir_left_q <= dir_left_d;
         sat_q      <= sat_d;
         fix_q      <= fix_d;
         ovf_q      <= ovf_d;
         ack_q      <= ack_d;
      end
   end

   // Next-state and datapath control: capture, classify, shift, pack.
   always_comb begin
      state_d    = state_q;
      sign_d     = sign_q;
      exp_d      = exp_q;
      mag_d      = mag_q;
      cnt_d      = cnt_q;
      dir_left_d = dir_left_q;
      sat_d      = sat_q;
      fix_d      = fix_q;
      ovf_d      = ovf_q;
      ack_d      = ack_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               sign_d  = flt_in[15];
               exp_d   = flt_in[14:10];
               mag_d   = {5'd0, 1'b1, flt_in[9:0]};
               cnt_d   = 5'd0;
               sat_d   = 1'b0;
               ack_d   = 1'b0;
               state_d = S_DECODE;
            end
         end

         S_DECODE: begin
            if ((exp_q == 5'd0) || ((exp_q < EXP_UNITY) && (rsh_w > MAX_RSH))) begin
               // Zero, subnormal or too small to reach the lowest fraction bit.
               mag_d   = 16'd0;
               state_d = S_PACK;
            end else if ((exp_q > EXP_SAT) ||
                         ((exp_q == EXP_SAT) && !(sign_q && mant_zero_w))) begin
               // Out of range, including inf/NaN; -256.0 exactly is representable.
               sat_d   = 1'b1;
               state_d = S_PACK;
            end else if (exp_q == EXP_UNITY) begin
               state_d = S_PACK;
            end else if (exp_q < EXP_UNITY) begin
               dir_left_d = 1'b0;
               cnt_d      = rsh_w;
               state_d    = S_SHIFT;
            end else begin
               dir_left_d = 1'b1;
               cnt_d      = exp_q - EXP_UNITY;
               state_d    = S_SHIFT;
            end
         end

         S_SHIFT: begin
            // Right shifts drop bits, i.e. the magnitude truncates toward zero.
            mag_d = dir_left_q ? (mag_q << 1) : (mag_q >> 1);
            cnt_d = cnt_q - 5'd1;
            if (cnt_q == 5'd1) begin
               state_d = S_PACK;
            end
         end

         S_PACK: begin
            if (sat_q) begin
               fix_d = sign_q ? 16'h8000 : 16'h7FFF;
            end else begin
               // Negating a zero magnitude yields zero, so no negative zero.
               fix_d = sign_q ? (~mag_q + 16'd1) : mag_q;
            end
            ovf_d   = sat_q;
            ack_d   = 1'b1;
            state_d = S_DONE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign ack     = ack_q;
   assign fix_out = fix_q;
   assign ovf     = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_flt_to_fix_conv.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module      : tb_flt_to_fix_conv                                          |
// | Description : Self-checking bench for flt_to_fix_conv against a numeric   |
// |               float16 -> 8.8 reference and a fixed -> float16 model.      |
// | Revision    : 1.0 - initial release                                       |
// +---------------------------------------------------------------------------+
module tb_flt_to_fix_conv;

   logic        clk;
   logic        reset;
   logic        start;
   logic [15:0] flt_in;
   logic        ack;
   logic [15:0] fix_out;
   logic        ovf;

   int n_total = 0;
   int n_bad   = 0;

   flt_to_fix_conv #(.MAX_RSHIFT(11)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .flt_in  (flt_in),
      .ack     (ack),
      .fix_out (fix_out),
      .ovf     (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Directed cases: input, expected result, expected ovf, expected latency.
   logic [15:0] d_in  [14] = '{16'h3C00, 16'hBC00, 16'h1C00, 16'h57FF, 16'hD800,
                               16'h5C00, 16'hD801, 16'h7C00, 16'hFE00, 16'h0000,
                               16'h8000, 16'h0200, 16'h1BFF, 16'h8400};
   logic [15:0] d_out [14] = '{16'h0100, 16'hFF00, 16'h0001, 16'h7FF0, 16'h8000,
                               16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 16'h0000,
                               16'h0000, 16'h0000, 16'h0000, 16'h0000};
   logic        d_ovf [14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                               1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                               1'b0, 1'b0, 1'b0, 1'b0};
   int          d_lat [14] = '{4, 4, 12, 6, 7, 2, 2, 2, 2, 2, 2, 2, 13, 2};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h want=%h", tag, got, exp);
      end
   endtask

   // Value of the float times 256, truncated toward zero, then saturated.
   function automatic void ref_conv(input logic [15:0] f, output logic [15:0] r,
                                    output logic o, output int lat);
      int     e;
      longint m;
      longint v;
      logic   sat;
      e = int'(f[14:10]);
      m = longint'({1'b1, f[9:0]});
      if (e == 0)       v = 0;
      else if (e >= 17) v = m << (e - 17);
      else              v = m >> (17 - e);
      sat = f[15] ? (v > 32768) : (v > 32767);
      if (sat) begin
         r = f[15] ? 16'h8000 : 16'h7FFF;
         o = 1'b1;
      end else begin
         r = f[15] ? 16'(-v) : 16'(v);
         o = 1'b0;
      end
      if (sat || e <= 5) lat = 2;
      else               lat = 2 + ((e >= 17) ? (e - 17) : (17 - e));
   endfunction

   // Fixed 8.8 -> float16 with truncation of bits below 11-bit precision.
   function automatic logic [15:0] fix2flt(input logic [15:0] x);
      int a;
      int p;
      int mant;
      if (x == 16'h0000) return 16'h0000;
      a = x[15] ? (65536 - int'(x)) : int'(x);
      p = 0;
      for (int i = 0; i < 16; i++) if (a >= (1 << i)) p = i;
      mant = (p >= 10) ? ((a >> (p - 10)) & 1023) : ((a << (10 - p)) & 1023);
      return {x[15], 5'(p + 7), 10'(mant)};
   endfunction

   function automatic logic [15:0] fix_trunc(input logic [15:0] x);
      int a;
      int p;
      if (x == 16'h0000) return 16'h0000;
      a = x[15] ? (65536 - int'(x)) : int'(x);
      p = 0;
      for (int i = 0; i < 16; i++) if (a >= (1 << i)) p = i;
      if (p >= 10) a = (a >> (p - 10)) << (p - 10);
      return x[15] ? 16'(65536 - a) : 16'(a);
   endfunction

   // One handshake; hold=2 keeps start high into DECODE, where it is ignored.
   task automatic run_conv(input logic [15:0] f, input int hold,
                           output logic [15:0] res, output logic o, output int cyc);
      bit got_ack;
      @(negedge clk);
      flt_in = f;
      start  = 1'b1;
      @(posedge clk);
      #1;
      if (hold == 1) start = 1'b0;
      check("ack_drop", 32'(ack), 32'(0));
      cyc     = 0;
      got_ack = 1'b0;
      while (!got_ack && cyc < 40) begin
         @(posedge clk);
         cyc++;
         #1;
         start = 1'b0;
         if (ack) got_ack = 1'b1;
      end
      if (!got_ack) check("ack_timeout", 32'(0), 32'(1));
      res = fix_out;
      o   = ovf;
   endtask

   initial begin
      logic [15:0] res;
      logic        o;
      int          cyc;
      logic [15:0] er;
      logic        eo;
      int          el;
      logic [15:0] x;
      logic [15:0] f;

      reset  = 1'b0;
      start  = 1'b0;
      flt_in = 16'h0000;
      #1;
      check("rst_ack", 32'(ack), 32'(0));
      check("rst_fix", 32'(fix_out), 32'(0));
      check("rst_ovf", 32'(ovf), 32'(0));
      repeat (3) @(negedge clk);
      reset = 1'b1;

      // Directed values straight from the expected-result table.
      for (int i = 0; i < 14; i++) begin
         run_conv(d_in[i], (i % 2) + 1, res, o, cyc);
         check($sformatf("dir_fix_%h", d_in[i]), 32'(res), 32'(d_out[i]));
         check($sformatf("dir_ovf_%h", d_in[i]), 32'(o), 32'(d_ovf[i]));
         check($sformatf("dir_lat_%h", d_in[i]), 32'(cyc), 32'(d_lat[i]));
      end

      // Result and ack held in DONE while start stays low.
      run_conv(16'hBC00, 1, res, o, cyc);
      repeat (3) @(posedge clk);
      #1;
      check("hold_ack", 32'(ack), 32'(1));
      check("hold_fix", 32'(fix_out), 32'(16'hFF00));

      // Start pulse in the middle of SHIFT must not disturb the conversion.
      @(negedge clk);
      flt_in = 16'h1C00;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc   = 0;
      while (!ack && cyc < 40) begin
         @(negedge clk);
         start  = (cyc == 5);
         flt_in = (cyc == 5) ? 16'h3C00 : 16'h1C00;
         @(posedge clk);
         cyc++;
         #1;
      end
      start = 1'b0;
      check("ign_fix", 32'(fix_out), 32'(16'h0001));
      check("ign_lat", 32'(cyc), 32'(12));

      // Asynchronous reset in the middle of SHIFT.
      run_conv(16'h3C00, 1, res, o, cyc);
      @(negedge clk);
      flt_in = 16'h1C00;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      check("arst_ack", 32'(ack), 32'(0));
      check("arst_fix", 32'(fix_out), 32'(0));
      check("arst_ovf", 32'(ovf), 32'(0));
      @(negedge clk);
      reset = 1'b1;
      repeat (15) @(posedge clk);
      #1;
      check("arst_no_ack", 32'(ack), 32'(0));
      run_conv(16'h3C00, 1, res, o, cyc);
      check("post_rst_fix", 32'(res), 32'(16'h0100));
      check("post_rst_lat", 32'(cyc), 32'(4));

      // Random float16 operands against the numeric reference.
      for (int i = 0; i < 100; i++) begin
         f = 16'($urandom_range(0, 65535));
         ref_conv(f, er, eo, el);
         run_conv(f, 1, res, o, cyc);
         check($sformatf("rnd_fix_%h", f), 32'(res), 32'(er));
         check($sformatf("rnd_ovf_%h", f), 32'(o), 32'(eo));
         check($sformatf("rnd_lat_%h", f), 32'(cyc), 32'(el));
      end

      // Round trip through the bench's fixed -> float16 model.
      for (int i = 0; i < 100; i++) begin
         x = 16'($urandom_range(0, 65535));
         if (x == 16'h8000) x = 16'h7FFF;
         run_conv(fix2flt(x), 1, res, o, cyc);
         check($sformatf("rt_fix_%h", x), 32'(res), 32'(fix_trunc(x)));
         check($sformatf("rt_ovf_%h", x), 32'(o), 32'(0));
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
